// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, slave codes and sequencer FSM states for the SPI command path.
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    localparam int SPI_SS_W   = 3;
    localparam logic [SPI_SS_W-1:0] SS_NONE   = 3'b111;
    localparam logic [SPI_SS_W-1:0] SS_SLAVE1 = 3'b000;
    localparam logic [SPI_SS_W-1:0] SS_SLAVE2 = 3'b001;
    localparam logic [SPI_SS_W-1:0] SS_SLAVE3 = 3'b010;
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} seq_state_e;
    function automatic logic ss_is_valid(input logic [SPI_SS_W-1:0] ss);
        return (ss == SS_SLAVE1) || (ss == SS_SLAVE2) || (ss == SS_SLAVE3);
    endfunction
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous FIFO with asynchronous active-high reset.
// Ports: clk_i, rst_i; push_i/wdata_i write side (ignored when full_o);
// pop_i/rdata_o read side (rdata_o shows the head, ignored when empty_o).
module spi_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    // one extra pointer bit tells a full ring from an empty one
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + {{AW{1'b0}}, do_push};
            rd_q <= rd_q + {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues host (slave, byte) commands and sequences them one at a time into the SPI stage.
// Ports: clk_i, rst_i (async, active-high); cmd_valid_i/cmd_ready_o/cmd_ss_i/cmd_data_i host command in;
// start_o/ss_o/data_m_o to the SPI stage; miso_data_i/sel_valid_i from it;
// rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o response out; busy_o activity flag.
// Build option SPI_SEQ_SKIP_INVALID_EN: invalid slave codes are answered with an error without launching.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int XFER_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [SPI_SS_W-1:0]   cmd_ss_i,
    input  logic [SPI_DATA_W-1:0] cmd_data_i,
    output logic                  start_o,
    output logic [SPI_SS_W-1:0]   ss_o,
    output logic [SPI_DATA_W-1:0] data_m_o,
    input  logic [SPI_DATA_W-1:0] miso_data_i,
    input  logic                  sel_valid_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [SPI_DATA_W-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(XFER_CYCLES) + 1;
    seq_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SPI_SS_W-1:0]   ss_q, ss_d, head_ss;
    logic [SPI_DATA_W-1:0] data_q, data_d, head_data;
    logic                  start_q, start_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [SPI_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  pop, full, empty;
    spi_cmd_fifo #(.WIDTH(SPI_SS_W + SPI_DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .wdata_i ({cmd_ss_i, cmd_data_i}),
        .pop_i   (pop),
        .rdata_o ({head_ss, head_data}),
        .full_o  (full),
        .empty_o (empty)
    );
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ss_d        = ss_q;
        data_d      = data_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
`ifdef SPI_SEQ_SKIP_INVALID_EN
                    if (!ss_is_valid(head_ss)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_LAUNCH;
                        start_d = 1'b1;
                        ss_d    = head_ss;
                        data_d  = head_data;
                    end
`else
                    state_d = ST_LAUNCH;
                    start_d = 1'b1;
                    ss_d    = head_ss;
                    data_d  = head_data;
`endif
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                cnt_d   = CW'(XFER_CYCLES - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = miso_data_i;
                    rsp_err_d   = !sel_valid_i;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    ss_d        = SS_NONE;
                    data_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ss_q        <= SS_NONE;
            data_q      <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ss_q        <= ss_d;
            data_q      <= data_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
    assign cmd_ready_o = !full;
    assign busy_o      = (state_q != ST_IDLE) || !empty;
    assign start_o     = start_q;
    assign ss_o        = ss_q;
    assign data_m_o    = data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed self-checking bench for spi_cmd_sequencer.
module tb_spi_cmd_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [2:0] cmd_ss = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, start, rsp_valid, rsp_err, busy, sel_valid;
    logic [2:0] ss_out;
    logic [7:0] data_m, miso, rsp_data;
    int         checks = 0, errors = 0, start_cnt = 0;
    logic [8:0] got_q[$];
    logic       prev_hold = 1'b0;
    logic [8:0] prev_rsp = '0;
    // slave model: returns the nibble-swapped transmit byte, selection valid for codes 0..2
    assign miso      = {data_m[3:0], data_m[7:4]};
    assign sel_valid = (ss_out == 3'b000) || (ss_out == 3'b001) || (ss_out == 3'b010);
    always #5 clk = ~clk;
    spi_cmd_sequencer #(.DEPTH(4), .XFER_CYCLES(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ss_i(cmd_ss), .cmd_data_i(cmd_data),
        .start_o(start), .ss_o(ss_out), .data_m_o(data_m),
        .miso_data_i(miso), .sel_valid_i(sel_valid),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .busy_o(busy)
    );
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (start) start_cnt++;
            if (prev_hold) begin
                checks++;
                if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== prev_rsp) begin
                    errors++;
                    $display("FAIL rsp_hold: got valid=%b rsp=%h, expected valid=1 rsp=%h", rsp_valid, {rsp_err, rsp_data}, prev_rsp);
                end
            end
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_data});
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_err, rsp_data};
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
    task automatic push(input logic [2:0] ss, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_ss    = ss;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_ready: got cmd_ready=0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask
    task automatic wait_rsps(input int n);
        int t = 0;
        while (got_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL rsp_count: got %0d expected %0d", got_q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ss_out !== 3'b111) begin errors++; $display("FAIL reset_ss: got %b expected 111", ss_out); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
        checks++; if (data_m !== 8'h00) begin errors++; $display("FAIL reset_data_m: got %h expected 00", data_m); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({rsp_err, rsp_data} !== 9'h000) begin errors++; $display("FAIL reset_rsp: got %h expected 000", {rsp_err, rsp_data}); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask
    task automatic test_single();
        rsp_ready = 1'b1;
        got_q.delete();
        push(3'b000, 8'hA5);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b expected 0", start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", start); end
        checks++; if ({ss_out, data_m} !== {3'b000, 8'hA5}) begin errors++; $display("FAIL single_launch: got ss=%b data=%h expected ss=000 data=a5", ss_out, data_m); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({start, rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_wait%0d: got start=%b valid=%b expected 0 0", i, start, rsp_valid); end
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if ({rsp_err, rsp_data} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL single_rsp: got err=%b data=%h expected err=0 data=5a", rsp_err, rsp_data); end
        @(negedge clk);
        checks++; if ({rsp_valid, ss_out, data_m} !== {1'b0, 3'b111, 8'h00}) begin errors++; $display("FAIL single_idle: got valid=%b ss=%b data=%h expected 0 111 00", rsp_valid, ss_out, data_m); end
        wait_rsps(1);
    endtask
    task automatic test_backpressure();
        int s0;
        logic [8:0] exp_r [5];
        exp_r = '{9'h05A, 9'h03C, 9'h04B, 9'h011, 9'h022};
        rsp_ready = 1'b0;
        got_q.delete();
        s0 = start_cnt;
        push(3'b000, 8'hA5);
        push(3'b001, 8'hC3);
        push(3'b010, 8'hB4);
        push(3'b000, 8'h11);
        push(3'b001, 8'h22);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got cmd_ready=%b expected 0", cmd_ready); end
        repeat (10) @(negedge clk);
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL bp_one_inflight: got %0d starts expected 1", start_cnt - s0); end
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 9'h05A}) begin errors++; $display("FAIL bp_held: got valid=%b rsp=%h expected 1 05a", rsp_valid, {rsp_err, rsp_data}); end
        rsp_ready = 1'b1;
        wait_rsps(5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_r[i]) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got_q[i], exp_r[i]); end
        end
        checks++; if (start_cnt - s0 != 5) begin errors++; $display("FAIL bp_starts: got %0d expected 5", start_cnt - s0); end
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL bp_drain: got ready=%b busy=%b expected 1 0", cmd_ready, busy); end
    endtask
    task automatic test_invalid();
        int s0;
        rsp_ready = 1'b1;
        got_q.delete();
        s0 = start_cnt;
        push(3'b111, 8'hFF);
        wait_rsps(1);
`ifdef SPI_SEQ_SKIP_INVALID_EN
        checks++; if (start_cnt - s0 != 0) begin errors++; $display("FAIL inv_starts: got %0d expected 0", start_cnt - s0); end
        checks++; if (got_q.size() > 0 && got_q[0] !== 9'h100) begin errors++; $display("FAIL inv_rsp: got %h expected 100", got_q[0]); end
`else
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL inv_starts: got %0d expected 1", start_cnt - s0); end
        checks++; if (got_q.size() > 0 && got_q[0] !== 9'h1FF) begin errors++; $display("FAIL inv_rsp: got %h expected 1ff", got_q[0]); end
`endif
    endtask
    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        got_q.delete();
        push(3'b000, 8'h01);
        push(3'b001, 8'h02);
        push(3'b010, 8'h03);
        @(negedge clk);
        checks++; if ({busy, cmd_ready} !== 2'b11) begin errors++; $display("FAIL mid_busy: got busy=%b ready=%b expected 1 1", busy, cmd_ready); end
        #3 rst = 1'b1;
        #1;
        checks++; if ({ss_out, data_m, start} !== {3'b111, 8'h00, 1'b0}) begin errors++; $display("FAIL mid_async: got ss=%b data=%h start=%b expected 111 00 0", ss_out, data_m, start); end
        checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin errors++; $display("FAIL mid_state: got valid=%b busy=%b ready=%b expected 0 0 1", rsp_valid, busy, cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != 0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_discard: got %0d rsps valid=%b busy=%b expected 0 0 0", got_q.size(), rsp_valid, busy); end
        test_single();
    endtask
    task automatic test_wrap();
        logic [7:0] d;
        logic [8:0] e;
        rsp_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 12; i++) begin
            push(3'(i % 3), 8'(i * 37 + 5));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_rsps(12);
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            d = 8'(i * 37 + 5);
            e = {1'b0, d[3:0], d[7:4]};
            checks++;
            if (got_q[i] !== e) begin errors++; $display("FAIL wrap%0d: got %h expected %h", i, got_q[i], e); end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
